// File: rtl/dcache_rsp_pkg.sv
// Shared types and width helpers for the dcache response queue.
// The struct types describe the default lane configuration that consumers see.
package dcache_rsp_pkg;

  localparam int NUM_REQS_DEF  = 4;
  localparam int WORD_SIZE_DEF = 4;
  localparam int TAG_WIDTH_DEF = 8;
  localparam int LANE_W        = 8 * WORD_SIZE_DEF;

  typedef logic [LANE_W-1:0] lane_word_t;

  typedef struct packed {
    logic [NUM_REQS_DEF-1:0]  tmask;
    lane_word_t [NUM_REQS_DEF-1:0] data;
    logic [TAG_WIDTH_DEF-1:0] tag;
  } rsp_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int entry_width(input int num_reqs, input int word_size, input int tag_width);
    return num_reqs + num_reqs * 8 * word_size + tag_width;
  endfunction

endpackage

// File: rtl/dcache_rsp_mem.sv
// DEPTH-entry response storage: one synchronous write port, one asynchronous read port.
// Storage is deliberately not reset; the queue gates the read data while empty.
module dcache_rsp_mem
  import dcache_rsp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = entry_width(NUM_REQS_DEF, WORD_SIZE_DEF, TAG_WIDTH_DEF)
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [ENTRY_W-1:0]          wdata,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [ENTRY_W-1:0]          rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dcache_rsp_queue.sv
// Buffered in-order dcache response queue with lane masking, optional
// discard of all-zero-mask responses, and occupancy / drop status.
module dcache_rsp_queue
  import dcache_rsp_pkg::*;
#(
  parameter int NUM_REQS       = 4,
  parameter int WORD_SIZE      = 4,
  parameter int TAG_WIDTH      = 8,
  parameter int DEPTH          = 4,
  parameter int DROP_EMPTY     = 1,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          in_valid,
  input  logic [NUM_REQS-1:0]           in_tmask,
  input  logic [NUM_REQS*8*WORD_SIZE-1:0] in_data,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [NUM_REQS-1:0]           out_tmask,
  output logic [NUM_REQS*8*WORD_SIZE-1:0] out_data,
  output logic [TAG_WIDTH-1:0]          out_tag,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          empty,
  output logic [DROP_CNT_WIDTH-1:0]     drop_cnt
);

  localparam int W       = 8 * WORD_SIZE;
  localparam int PTR_W   = ptr_width(DEPTH);
  localparam int CNT_W   = cnt_width(DEPTH);
  localparam int ENTRY_W = entry_width(NUM_REQS, WORD_SIZE, TAG_WIDTH);

  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          count_q;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;
  logic                      drop;
  logic                      push;
  logic                      pop;
  logic                      drop_event;
  logic                      full_w;
  logic                      empty_w;
  logic [NUM_REQS*W-1:0]     masked_data;
  logic [ENTRY_W-1:0]        wr_entry;
  logic [ENTRY_W-1:0]        rd_entry;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_lane_mask
      assign masked_data[gi*W +: W] = in_tmask[gi] ? in_data[gi*W +: W] : '0;
    end
  endgenerate

  assign drop       = (DROP_EMPTY != 0) && (in_tmask == '0);
  assign full_w     = (count_q == CNT_W'(DEPTH));
  assign empty_w    = (count_q == '0);
  // Dropped responses are always accepted, even with the queue full.
  assign in_ready   = !full_w || drop;
  assign push       = in_valid && in_ready && !drop;
  assign drop_event = in_valid && drop;
  assign pop        = !empty_w && out_ready;
  assign wr_entry   = {in_tmask, masked_data, in_tag};

  dcache_rsp_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop_event && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
      end
    end
  end

  // Gating on empty keeps stale storage invisible, including right after reset.
  assign {out_tmask, out_data, out_tag} = empty_w ? '0 : rd_entry;
  assign out_valid = !empty_w;
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_dcache_rsp_queue.sv
// Directed bench for dcache_rsp_queue: one instance with discard enabled,
// one with discard disabled for the all-zero-mask comparison.
module tb_dcache_rsp_queue;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;

  logic         in_valid = 1'b0;
  logic [3:0]   in_tmask = '0;
  logic [127:0] in_data = '0;
  logic [7:0]   in_tag = '0;
  logic         in_ready;
  logic         out_valid;
  logic [3:0]   out_tmask;
  logic [127:0] out_data;
  logic [7:0]   out_tag;
  logic         out_ready = 1'b0;
  logic [2:0]   count;
  logic         full;
  logic         empty;
  logic [15:0]  drop_cnt;

  logic         b_in_valid = 1'b0;
  logic [3:0]   b_in_tmask = '0;
  logic [127:0] b_in_data = '0;
  logic [7:0]   b_in_tag = '0;
  logic         b_in_ready;
  logic         b_out_valid;
  logic [3:0]   b_out_tmask;
  logic [127:0] b_out_data;
  logic [7:0]   b_out_tag;
  logic         b_out_ready = 1'b0;
  logic [2:0]   b_count;
  logic         b_full;
  logic         b_empty;
  logic [15:0]  b_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dcache_rsp_queue #(.DROP_EMPTY(1)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_tmask(in_tmask), .in_data(in_data), .in_tag(in_tag),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_tmask(out_tmask), .out_data(out_data), .out_tag(out_tag),
    .out_ready(out_ready),
    .count(count), .full(full), .empty(empty), .drop_cnt(drop_cnt)
  );

  dcache_rsp_queue #(.DROP_EMPTY(0)) dut_keep (
    .CLK(CLK), .nRST(nRST),
    .in_valid(b_in_valid), .in_tmask(b_in_tmask), .in_data(b_in_data), .in_tag(b_in_tag),
    .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_tmask(b_out_tmask), .out_data(b_out_data), .out_tag(b_out_tag),
    .out_ready(b_out_ready),
    .count(b_count), .full(b_full), .empty(b_empty), .drop_cnt(b_drop_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_full_mask(input logic [7:0] tag);
    in_valid = 1'b1;
    in_tmask = 4'hF;
    in_data  = {4{24'h0, tag}};
    in_tag   = tag;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    // 1: reset and idle
    #12 nRST = 1'b1;
    step();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_count", 128'(count), 128'd0);
    check("rst_empty", 128'(empty), 128'd1);
    check("rst_full", 128'(full), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_drop_cnt", 128'(drop_cnt), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_out_tag", 128'(out_tag), 128'd0);

    // 2: fill to full, then drain in order
    for (int i = 0; i < 4; i++) begin
      push_full_mask(8'h10 + 8'(i));
      check("fill_count", 128'(count), 128'(i + 1));
    end
    check("fill_full", 128'(full), 128'd1);
    check("fill_in_ready", 128'(in_ready), 128'd0);
    check("fill_empty", 128'(empty), 128'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 128'(out_valid), 128'd1);
      check("drain_tag", 128'(out_tag), 128'(8'h10 + 8'(i)));
      step();
    end
    check("drain_empty", 128'(empty), 128'd1);
    check("drain_out_valid", 128'(out_valid), 128'd0);
    out_ready = 1'b0;

    // 3: simultaneous push and pop holds occupancy
    push_full_mask(8'h20);
    push_full_mask(8'h21);
    check("pp_count0", 128'(count), 128'd2);
    in_valid  = 1'b1;
    in_tmask  = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_tag = 8'h22 + 8'(k);
      check("pp_head", 128'(out_tag), 128'(8'h20 + 8'(k)));
      step();
      check("pp_count", 128'(count), 128'd2);
    end
    in_valid = 1'b0;
    check("pp_tail0", 128'(out_tag), 128'h23);
    step();
    check("pp_tail1", 128'(out_tag), 128'h24);
    step();
    check("pp_empty", 128'(empty), 128'd1);
    out_ready = 1'b0;

    // 4: all-zero mask discarded when empty and when full
    in_valid = 1'b1;
    in_tmask = 4'h0;
    in_tag   = 8'h99;
    #1 check("drop_e_in_ready", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    check("drop_e_count", 128'(count), 128'd0);
    check("drop_e_cnt", 128'(drop_cnt), 128'd1);
    check("drop_e_valid", 128'(out_valid), 128'd0);
    for (int i = 0; i < 4; i++) push_full_mask(8'h30 + 8'(i));
    check("drop_f_full", 128'(full), 128'd1);
    in_valid = 1'b1;
    in_tmask = 4'h0;
    #1 check("drop_f_in_ready", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    check("drop_f_count", 128'(count), 128'd4);
    check("drop_f_cnt", 128'(drop_cnt), 128'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drop_f_tag", 128'(out_tag), 128'(8'h30 + 8'(i)));
      step();
    end
    out_ready = 1'b0;
    check("drop_f_empty", 128'(empty), 128'd1);

    b_in_valid = 1'b1;
    b_in_tmask = 4'h0;
    b_in_data  = {4{32'hDEADBEEF}};
    b_in_tag   = 8'h55;
    #1 check("keep_in_ready", 128'(b_in_ready), 128'd1);
    step();
    b_in_valid = 1'b0;
    check("keep_count", 128'(b_count), 128'd1);
    check("keep_drop_cnt", 128'(b_drop_cnt), 128'd0);
    check("keep_tag", 128'(b_out_tag), 128'h55);
    check("keep_data", b_out_data, 128'd0);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    check("keep_empty", 128'(b_empty), 128'd1);

    // 5: lane masking, and no same-cycle fall-through
    in_valid = 1'b1;
    in_tmask = 4'b0101;
    in_data  = {4{32'hFFFFFFFF}};
    in_tag   = 8'h66;
    #1 check("mask_no_bypass", 128'(out_valid), 128'd0);
    step();
    in_valid = 1'b0;
    check("mask_tmask", 128'(out_tmask), 128'h5);
    check("mask_data", out_data, 128'h00000000_FFFFFFFF_00000000_FFFFFFFF);
    check("mask_tag", 128'(out_tag), 128'h66);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // 6: asynchronous reset with entries pending
    for (int i = 0; i < 3; i++) push_full_mask(8'h70 + 8'(i));
    check("ar_count3", 128'(count), 128'd3);
    check("ar_drop_pre", 128'(drop_cnt), 128'd2);
    #2 nRST = 1'b0;
    #1;
    check("ar_out_valid", 128'(out_valid), 128'd0);
    check("ar_count", 128'(count), 128'd0);
    check("ar_drop_cnt", 128'(drop_cnt), 128'd0);
    check("ar_empty", 128'(empty), 128'd1);
    check("ar_out_tag", 128'(out_tag), 128'd0);
    #1 nRST = 1'b1;
    in_valid = 1'b1;
    in_tmask = 4'hF;
    in_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    in_tag   = 8'h80;
    step();
    in_valid = 1'b0;
    check("ar_post_valid", 128'(out_valid), 128'd1);
    check("ar_post_tag", 128'(out_tag), 128'h80);
    check("ar_post_data", out_data, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    check("ar_post_count", 128'(count), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
